// File: rtl/morse_key_fsm.sv
// Morse key front end: synchronizes the key, times each press as a dot or dash,
// packs up to four symbols per letter and commits the letter after a release gap.
module morse_key_fsm #(
  parameter int MIN_TICKS  = 2,
  parameter int DASH_TICKS = 8,
  parameter int GAP_TICKS  = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [3:0] fsm_in,
  output logic [2:0] bits,
  output logic       letter_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  logic             key_meta_reg;
  logic             key_s_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;
  logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [3:0]       fsm_in_reg, fsm_in_next;
  logic [2:0]       bits_reg, bits_next;
  logic             err_reg, err_next;
  logic             letter_valid_reg, letter_valid_next;
  logic             new_letter_reg, new_letter_next;
  logic             sym;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_reg     <= 1'b0;
      key_s_reg        <= 1'b0;
      state_reg        <= IDLE;
      press_cnt_reg    <= '0;
      gap_cnt_reg      <= '0;
      fsm_in_reg       <= 4'd0;
      bits_reg         <= 3'd0;
      err_reg          <= 1'b0;
      letter_valid_reg <= 1'b0;
      new_letter_reg   <= 1'b1;
    end else begin
      key_meta_reg     <= key;
      key_s_reg        <= key_meta_reg;
      state_reg        <= state_next;
      press_cnt_reg    <= press_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      fsm_in_reg       <= fsm_in_next;
      bits_reg         <= bits_next;
      err_reg          <= err_next;
      letter_valid_reg <= letter_valid_next;
      new_letter_reg   <= new_letter_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    press_cnt_next    = press_cnt_reg;
    gap_cnt_next      = gap_cnt_reg;
    fsm_in_next       = fsm_in_reg;
    bits_next         = bits_reg;
    err_next          = err_reg;
    letter_valid_next = 1'b0;
    new_letter_next   = new_letter_reg;
    sym               = 1'b0;

    case (state_reg)
      IDLE: begin
        if (key_s_reg) begin
          state_next     = PRESS;
          press_cnt_next = CNT_ONE;
        end
      end

      PRESS: begin
        if (key_s_reg) begin
          if (press_cnt_reg < DASH_CNT)
            press_cnt_next = press_cnt_reg + CNT_ONE;
        end else begin
          gap_cnt_next = '0;
          if (press_cnt_reg < MIN_CNT) begin
            // Glitch: a committed letter stays on display untouched.
            state_next = new_letter_reg ? IDLE : GAP;
          end else begin
            state_next = GAP;
            sym        = (press_cnt_reg >= DASH_CNT);
            if (new_letter_reg) begin
              fsm_in_next     = {3'b000, sym};
              bits_next       = 3'd1;
              err_next        = 1'b0;
              new_letter_next = 1'b0;
            end else if (err_reg) begin
              fsm_in_next = 4'd0;
              bits_next   = 3'd0;
            end else if (bits_reg < 3'd4) begin
              fsm_in_next[bits_reg[1:0]] = sym;
              bits_next                  = bits_reg + 3'd1;
            end else begin
              // Fifth symbol: blank the display so the decoder never sees bits > 4.
              err_next    = 1'b1;
              fsm_in_next = 4'd0;
              bits_next   = 3'd0;
            end
          end
        end
      end

      GAP: begin
        if (key_s_reg) begin
          state_next     = PRESS;
          press_cnt_next = CNT_ONE;
        end else begin
          gap_cnt_next = gap_cnt_reg + CNT_ONE;
          if (gap_cnt_next == GAP_LAST) begin
            state_next        = IDLE;
            gap_cnt_next      = '0;
            letter_valid_next = !err_reg && (bits_reg != 3'd0);
            new_letter_next   = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fsm_in       = fsm_in_reg;
  assign bits         = bits_reg;
  assign err          = err_reg;
  assign letter_valid = letter_valid_reg;

endmodule
